ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries; legal values 2 and 4.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump taken from execute stage.
REQ-011 SHALL have port redirect_pc  input  32  new fetch target.
REQ-012 SHALL have port if_valid  output  1  instruction available to decode.
REQ-013 SHALL have port if_ready  input  1  decode consumes instruction.
REQ-014 SHALL have port if_instr  output  32  instruction word to decode.
REQ-015 SHALL have port if_pc  output  32  address of if_instr; drives the core pc observation.

Function
REQ-016 SHALL hold fetch_pc; each accepted request (imem_req_valid && imem_req_ready) advances fetch_pc by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-017 SHALL drive imem_addr = fetch_pc and assert imem_req_valid only when occupancy + outstanding < DEPTH and redirect_valid is low.
REQ-018 SHALL track outstanding (accepted, unanswered requests) in a counter of width clog2(DEPTH)+1.
REQ-019 SHALL write each non-dropped response {pc, data} into a FIFO of DEPTH entries; pc is the address of the matching request.
REQ-020 SHALL present the FIFO head on if_instr/if_pc with if_valid = FIFO not empty; zero latency, no combinational path from if_ready to if_valid.
REQ-021 SHALL pop the head when if_valid && if_ready; simultaneous push and pop with FIFO full SHALL succeed, occupancy unchanged.
REQ-022 SHALL make minimum fetch latency request-accept -> if_valid equal to memory latency + 1 cycle.
REQ-023 On redirect_valid, SHALL in that cycle flush the FIFO, set fetch_pc = {redirect_pc[31:2], 2'b00}, move outstanding into drop_cnt, clear outstanding.
REQ-024 SHALL discard (not push) responses while drop_cnt > 0, decrementing drop_cnt per response.
REQ-025 A response arriving in the redirect cycle SHALL be counted in the drop transfer (dropped).
REQ-026 SHALL give redirect priority over push, pop and issue in the same cycle; if_valid may be high that cycle but the pop is ignored.
REQ-027 SHALL treat a response with outstanding == 0 and drop_cnt == 0 as a protocol error: ignored, no state change.
REQ-028 SHALL keep a 2-state issue FSM: RUN (issue permitted), DRAIN (drop_cnt > 0, issue permitted at new PC); DRAIN -> RUN when drop_cnt reaches 0.

Reset
REQ-029 rst low SHALL immediately force fetch_pc = RESET_PC, FIFO empty, outstanding = 0, drop_cnt = 0, FSM = RUN.
REQ-030 During reset SHALL drive imem_req_valid = 0, if_valid = 0, if_instr = 0, if_pc = 0.
REQ-031 First request SHALL issue on the first rising clk edge after rst deasserts; reset mid-fetch SHALL abandon in-flight responses.

Structure
REQ-032 SHALL place XLEN (32), instruction width, RESET_PC default and NOP encoding (32'h0000_0013) in the shared cpu package.
REQ-033 SHALL implement the buffer as sub-module ifetch_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-034 Reset release, 1-cycle memory returning addr as data, if_ready=1 -> if_pc 0,4,8,12 on consecutive cycles after fill, if_instr == if_pc.
REQ-035 if_ready=0 for 10 cycles -> exactly DEPTH requests issued, then imem_req_valid stays 0; FIFO holds PCs 0 and 4.
REQ-036 Redirect to 32'h0000_0102 with 2 outstanding -> both stale responses dropped, next if_pc = 32'h0000_0100.
REQ-037 imem_req_ready toggling 1/0 with 3-cycle response latency -> no duplicate or lost PC, strictly ascending by 4.
REQ-038 fetch_pc forced near 32'hFFFF_FFF8 via redirect -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst asserted while 2 requests outstanding, released -> late responses ignored, first if_pc = RESET_PC.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch slice: word widths,
// reset vector default, NOP encoding, the fetch buffer entry layout and
// small PC arithmetic helpers.
package ifetch_unit_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

   // One buffered fetch result: the address it was fetched from and the word.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   // Force a target address onto a word boundary.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(3);
   endfunction

   // Address of the request issued 'words' requests before 'pc' (wraps mod 2^32).
   function automatic logic [XLEN-1:0] pc_back(input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] words);
      return pc - (words << 2);
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries. Supports
// push and pop in the same cycle even when full, and a single-cycle flush.
module ifetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;

   logic w_push_ok;
   logic w_pop_ok;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == {(AW+1){1'b0}});
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);

   // Storage write; contents are cleared on reset so the head never shows X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else if (w_push_ok && !i_flush) begin
         r_mem[r_wptr] <= i_push_data;
      end else begin
         r_mem[r_wptr] <= r_mem[r_wptr];
      end
   end

   // Pointer and occupancy bookkeeping; flush empties the buffer at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {(AW+1){1'b0}};
      end else if (i_flush) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {(AW+1){1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + AW'(1);
         end else begin
            r_wptr <= r_wptr;
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + AW'(1);
         end else begin
            r_rptr <= r_rptr;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches while buffer space
// remains, pairs in-order memory responses with their addresses, buffers
// them for decode, and discards responses made stale by a redirect.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [ILEN-1:0]   imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ILEN-1:0]   if_instr,
   output logic [XLEN-1:0]   if_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   // Drops accumulate across back-to-back redirects, so give them headroom.
   localparam int DW = CW + 3;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [XLEN-1:0] r_fetch_pc;
   logic [CW-1:0]   r_outstanding;
   logic [DW-1:0]   r_drop_cnt;
   logic [0:0]      r_state;

   logic [XLEN-1:0] w_pc_nxt;
   logic [CW-1:0]   w_out_nxt;
   logic [DW-1:0]   w_drop_nxt;
   logic [0:0]      w_state_nxt;

   logic [CW-1:0]   w_occ;
   logic [CW:0]     w_inflight;
   logic            w_room;
   logic            w_req_fire;
   logic            w_rsp_take;
   logic            w_rsp_drop;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [DW-1:0]   w_drop_total;
   logic [XLEN-1:0] w_rsp_pc;
   fetch_entry_t    w_push_entry;
   fetch_entry_t    w_head;

   // Buffered entries plus requests still in flight must fit in the FIFO,
   // which guarantees every accepted response has a free slot.
   assign w_inflight     = {1'b0, w_occ} + {1'b0, r_outstanding};
   assign w_room         = (w_inflight < (CW+1)'(DEPTH));
   assign imem_req_valid = rst & ~redirect_valid & w_room;
   assign imem_addr      = r_fetch_pc;
   assign w_req_fire     = imem_req_valid & imem_req_ready;

   // Outstanding requests are contiguous and end just below fetch_pc, so the
   // oldest one's address is recovered without a separate address queue.
   assign w_rsp_pc       = pc_back(r_fetch_pc, XLEN'(r_outstanding));
   assign w_rsp_drop     = imem_rsp_valid & (r_drop_cnt != {DW{1'b0}});
   assign w_rsp_take     = imem_rsp_valid & ~redirect_valid
                         & (r_drop_cnt == {DW{1'b0}})
                         & (r_outstanding != {CW{1'b0}});
   assign w_drop_total   = r_drop_cnt + DW'(r_outstanding);

   assign w_push_entry.pc    = w_rsp_pc;
   assign w_push_entry.instr = imem_rsp_data;

   // A redirect kills the pop: decode must not consume a squashed instruction.
   assign w_pop     = if_valid & if_ready & ~redirect_valid;

   assign if_valid  = ~w_empty;
   assign if_instr  = w_empty ? {ILEN{1'b0}} : w_head.instr;
   assign if_pc     = w_empty ? {XLEN{1'b0}} : w_head.pc;

   ifetch_fifo #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst),
      .i_flush     (redirect_valid),
      .i_push      (w_rsp_take),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_occ)
   );

   // Next-state for fetch PC, in-flight count, stale-drop count and FSM.
   always_comb begin
      w_pc_nxt    = r_fetch_pc;
      w_out_nxt   = r_outstanding;
      w_drop_nxt  = r_drop_cnt;
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_pc_nxt  = align_pc(redirect_pc);
         w_out_nxt = {CW{1'b0}};
         // A response landing in the redirect cycle answers one of the
         // requests being moved to the drop count.
         if (imem_rsp_valid && (w_drop_total != {DW{1'b0}})) begin
            w_drop_nxt = w_drop_total - DW'(1);
         end else begin
            w_drop_nxt = w_drop_total;
         end
      end else begin
         if (w_req_fire) begin
            w_pc_nxt = r_fetch_pc + 32'd4;
         end else begin
            w_pc_nxt = r_fetch_pc;
         end
         case ({w_req_fire, w_rsp_take})
            2'b10:   w_out_nxt = r_outstanding + CW'(1);
            2'b01:   w_out_nxt = r_outstanding - CW'(1);
            default: w_out_nxt = r_outstanding;
         endcase
         if (w_rsp_drop) begin
            w_drop_nxt = r_drop_cnt - DW'(1);
         end else begin
            w_drop_nxt = r_drop_cnt;
         end
      end
      case (r_state)
         ST_RUN:   w_state_nxt = (w_drop_nxt != {DW{1'b0}}) ? ST_DRAIN : ST_RUN;
         ST_DRAIN: w_state_nxt = (w_drop_nxt != {DW{1'b0}}) ? ST_DRAIN : ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // Fetch control state; reset abandons anything still in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= {CW{1'b0}};
         r_drop_cnt    <= {DW{1'b0}};
         r_state       <= ST_RUN;
      end else begin
         r_fetch_pc    <= w_pc_nxt;
         r_outstanding <= w_out_nxt;
         r_drop_cnt    <= w_drop_nxt;
         r_state       <= w_state_nxt;
      end
   end

endmodule
